// File: rtl/serial_adder.sv
// serial_adder -- bit-serial WIDTH-bit adder.
//
// A single 1-bit full-adder slice and a carry flop process the operands
// LSB first, one bit per clock. A start pulse captures a, b and c_in. The
// sum bits then collect in an internal shift register. When the last bit
// is done, sum and c_out are updated and done pulses for one cycle.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin an addition (accepted in idle or in the done cycle)
//   a, b   in   WIDTH-bit operands, captured on the accept edge
//   c_in   in   carry-in, captured on the accept edge
//   busy   out  high while bits are shifted through the slice
//   done   out  one-cycle pulse, result valid from this cycle onward
//   sum    out  WIDTH-bit result register
//   c_out  out  final carry register

// Behavioural 1-bit full-adder cell: the slice used by serial_adder.
module full_adder_behavioural (
   output logic sum,
   output logic c_out,
   input  logic a,
   input  logic b,
   input  logic c_in
);

   always_comb begin
      sum   = a ^ b ^ c_in;
      c_out = (a & b) | (c_in & (a ^ b));
   end

endmodule

module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   // The counter must be able to hold WIDTH.
   localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
   logic [WIDTH:0]   sum_cat;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             slice_sum, slice_cout;
   logic             last, accept, shift_en;

   full_adder_behavioural u_slice (
      .sum   (slice_sum),
      .c_out (slice_cout),
      .a     (a_sh[0]),
      .b     (b_sh[0]),
      .c_in  (carry)
   );

   always_comb begin
      last     = (cnt == CW'(WIDTH - 1));
      // The new bit enters at the MSB. Concatenating before the shift
      // keeps this legal for WIDTH == 1.
      sum_cat  = {slice_sum, sum_sh};
      sum_next = sum_cat[WIDTH:1];
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      shift_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               state_d = StShift;
            end
         end
         StShift: begin
            // start is ignored here; nothing is queued.
            shift_en = 1'b1;
            if (last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (start) begin
               accept  = 1'b1;
               state_d = StShift;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StShift);
      done = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         c_out  <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= c_in;
         cnt   <= '0;
      end else if (shift_en) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         carry  <= slice_cout;
         sum_sh <= sum_next;
         cnt    <= cnt + CW'(1);
         // The visible result changes only once, at the end of the operation.
         if (last) begin
            sum   <= sum_next;
            c_out <= slice_cout;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: one WIDTH=8 and one WIDTH=1 instance.
// The reference result is {c_out,sum} = a + b + c_in, computed with plain
// arithmetic. The bench also checks the timing: done comes WIDTH edges
// after the accept edge.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;

   logic       start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .c_in  (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .c_out (cout8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .a     (a1),
      .b     (b1),
      .c_in  (cin1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .c_out (cout1)
   );

   // Runs one operation on the selected instance. It returns the result,
   // the number of edges from the accept edge to done (or -1 on timeout),
   // and the number of sampled cycles with busy high.
   task automatic do_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input bit scramble,
                        output logic [7:0] s, output logic c, output int lat,
                        output int busy_n);
      int w;
      w      = sel ? 1 : 8;
      lat    = -1;
      busy_n = 0;
      s      = '0;
      c      = 1'b0;
      @(posedge clk); #1;
      if (sel) begin
         a1 = a[0]; b1 = b[0]; cin1 = cin; start1 = 1'b1;
      end else begin
         a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
      end
      @(posedge clk);  // accept edge
      for (int k = 1; k <= w + 4; k++) begin
         #1;
         if (sel) begin
            start1 = 1'b0;
         end else if (scramble) begin
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            cin8   = 1'($urandom);
            // Start pulses while shifting must be ignored.
            start8 = (k <= w) ? 1'($urandom) : 1'b0;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         if (sel ? busy1 : busy8) busy_n++;
         if (sel ? done1 : done8) begin
            lat = k - 1;
            s   = sel ? {7'b0, sum1} : sum8;
            c   = sel ? cout1 : cout8;
            break;
         end
         @(posedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_w8: busy/done/c_out/sum = %b %b %b %h, required all 0",
                  busy8, done8, cout8, sum8);
      end
      n_checks++;
      if ({busy1, done1, cout1, sum1} !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_w1: busy/done/c_out/sum = %b %b %b %b, required all 0",
                  busy1, done1, cout1, sum1);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] va [3] = '{8'hA5, 8'hFF, 8'hFF};
      logic [7:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
      logic       vc [3] = '{1'b0, 1'b0, 1'b1};
      logic [8:0] expv [3] = '{9'h0E1, 9'h100, 9'h1FF};
      logic [7:0] s;
      logic       c;
      int         lat, bn;
      for (int i = 0; i < 3; i++) begin
         do_op(1'b0, va[i], vb[i], vc[i], 1'b0, s, c, lat, bn);
         n_checks++;
         if ({c, s} !== expv[i]) begin
            n_fail++;
            $display("FAIL directed_result[%0d]: got %h, required %h", i, {c, s}, expv[i]);
         end
         n_checks++;
         if (lat != 8) begin
            n_fail++;
            $display("FAIL directed_latency[%0d]: got %0d, required 8", i, lat);
         end
         n_checks++;
         if (bn != 8) begin
            n_fail++;
            $display("FAIL directed_busy_cycles[%0d]: got %0d, required 8", i, bn);
         end
         @(negedge clk);
         n_checks++;
         if (done8 !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_done_pulse[%0d]: done=%b one cycle later, required 0",
                     i, done8);
         end
      end
   endtask

   // start stays high and the operands change every cycle. The accept edges
   // are 0, 9, 18, 27. Each result belongs to the operands on its accept edge.
   task automatic test_back_to_back();
      logic [8:0] ref_v [36];
      logic       exp_done;
      @(posedge clk); #1;
      for (int e = 0; e < 36; e++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
         ref_v[e] = {1'b0, a8} + {1'b0, b8} + {8'b0, cin8};
         @(posedge clk); #1;
         exp_done = ((e % 9) == 8);
         n_checks++;
         if (done8 !== exp_done || busy8 !== !exp_done) begin
            n_fail++;
            $display("FAIL b2b_timing[edge %0d]: done=%b busy=%b, required done=%b busy=%b",
                     e, done8, busy8, exp_done, !exp_done);
         end
         if (exp_done) begin
            n_checks++;
            if ({cout8, sum8} !== ref_v[e - 8]) begin
               n_fail++;
               $display("FAIL b2b_result[edge %0d]: got %h, required %h", e, {cout8, sum8},
                        ref_v[e - 8]);
            end
         end
      end
      start8 = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      logic [7:0] s;
      logic       c;
      int         lat, bn, seen;
      logic [7:0] ra, rb;
      @(posedge clk); #1;
      a8 = 8'h5A; b8 = 8'h77; cin8 = 1'b1; start8 = 1'b1;
      @(posedge clk);  // accept edge
      #1 start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: busy/done/c_out/sum = %b %b %b %h, required all 0",
                  busy8, done8, cout8, sum8);
      end
      #2 rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_done: %0d busy/done cycles after release, required 0",
                  seen);
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(1'b0, ra, rb, 1'b1, 1'b0, s, c, lat, bn);
      n_checks++;
      if ({c, s} !== ({1'b0, ra} + {1'b0, rb} + 9'd1) || lat != 8) begin
         n_fail++;
         $display("FAIL reset_mid_next_op: got %h lat %0d, required %h lat 8", {c, s}, lat,
                  {1'b0, ra} + {1'b0, rb} + 9'd1);
      end
   endtask

   task automatic test_random();
      logic [7:0] s, ra, rb;
      logic       c, rc;
      int         lat, bn;
      logic [8:0] expv;
      for (int i = 0; i < 1000; i++) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rc   = 1'($urandom);
         expv = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
         do_op(1'b0, ra, rb, rc, 1'b1, s, c, lat, bn);
         n_checks++;
         if ({c, s} !== expv || lat != 8) begin
            n_fail++;
            $display("FAIL random[%0d]: %h+%h+%b got %h lat %0d, required %h lat 8", i, ra, rb,
                     rc, {c, s}, lat, expv);
         end
      end
   endtask

   task automatic test_width1();
      logic [7:0] s;
      logic       c;
      int         lat, bn;
      logic [1:0] expv;
      for (int v = 0; v < 8; v++) begin
         expv = 2'(v[2] + v[1] + v[0]);
         do_op(1'b1, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0, s, c, lat, bn);
         n_checks++;
         if ({c, s[0]} !== expv || lat != 1) begin
            n_fail++;
            $display("FAIL width1[a=%0d b=%0d c=%0d]: got %b lat %0d, required %b lat 1",
                     v[2], v[1], v[0], {c, s[0]}, lat, expv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_width1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
